// File: rtl/data_mem_param_pkg.sv
// rtl/data_mem_param_pkg.sv - shared encodings for the data memory slice
// sign_mask bit positions, FSM states, access-size codes and the size decoder.
package data_mem_param_pkg;

  localparam int MASK_BYTE = 0;
  localparam int MASK_HALF = 1;
  localparam int MASK_WORD = 2;
  localparam int MASK_SIGN = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LOAD  = 2'd2,
    ST_STORE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SZ_NONE = 2'd0,
    SZ_BYTE = 2'd1,
    SZ_HALF = 2'd2,
    SZ_WORD = 2'd3
  } size_e;

  // Widest requested size wins when the core sets more than one size bit.
  function automatic size_e decode_size(input logic [3:0] mask);
    if (mask[MASK_WORD]) return SZ_WORD;
    if (mask[MASK_HALF]) return SZ_HALF;
    if (mask[MASK_BYTE]) return SZ_BYTE;
    return SZ_NONE;
  endfunction

endpackage

// File: rtl/data_mem_param_if.sv
// rtl/data_mem_param_if.sv - MEM-stage request/response bus between core and data memory
// The core drives the master side; the memory answers on the slave side.
interface data_mem_param_if #(
  parameter int ADDR_WIDTH = 14
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           write_data;
  logic                  memwrite;
  logic                  memread;
  logic [3:0]            sign_mask;
  logic [31:0]           read_data;
  logic                  clk_stall;
  logic                  access_err;

  modport master (
    output addr, write_data, memwrite, memread, sign_mask,
    input  read_data, clk_stall, access_err
  );

  modport slave (
    input  addr, write_data, memwrite, memread, sign_mask,
    output read_data, clk_stall, access_err
  );
endinterface

// File: rtl/data_mem_param_lane_fmt.sv
// rtl/data_mem_param_lane_fmt.sv - byte/half/word lane extraction and store merge
// Purely combinational; works on one 32-bit RAM word and the low address bits.
module data_mem_param_lane_fmt
  import data_mem_param_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_offset,
  input  logic [3:0]  i_sign_mask,
  output logic [31:0] o_load_word,
  output logic [31:0] o_store_word
);

  size_e       w_size;
  logic        w_sign;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_size       = decode_size(i_sign_mask);
    w_sign       = i_sign_mask[MASK_SIGN];
    w_byte       = i_word[{i_offset, 3'b000} +: 8];
    w_half       = i_offset[1] ? i_word[31:16] : i_word[15:0];
    o_load_word  = 32'h0;
    o_store_word = i_word;
    case (w_size)
      SZ_BYTE: begin
        o_load_word = {{24{w_sign & w_byte[7]}}, w_byte};
        o_store_word[{i_offset, 3'b000} +: 8] = i_wdata[7:0];
      end
      SZ_HALF: begin
        o_load_word = {{16{w_sign & w_half[15]}}, w_half};
        if (i_offset[1]) o_store_word[31:16] = i_wdata[15:0];
        else             o_store_word[15:0]  = i_wdata[15:0];
      end
      SZ_WORD: begin
        o_load_word  = i_word;
        o_store_word = i_wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_param.sv
// rtl/data_mem_param.sv - RV32 data memory: stall FSM, word RAM, LED register, access checks
// Every request takes IDLE -> FETCH -> LOAD/STORE, so clk_stall is high for exactly two cycles.
module data_mem_param
  import data_mem_param_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 14,
  parameter int                    DEPTH_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 14'h1000,
  parameter logic [ADDR_WIDTH-1:0] LED_ADDR    = 14'h2000,
  parameter int                    LED_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  data_mem_param_if.slave      io_bus,
  output logic [LED_WIDTH-1:0] o_led
);

  localparam int                  IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_WIDTH:0] SPAN  = (ADDR_WIDTH+1)'(4 * DEPTH_WORDS);

  state_e                r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata, r_word_buf, r_read_data, r_led;
  logic [3:0]            r_mask;
  logic                  r_is_load, r_stall, r_err;
  logic [31:0]           r_mem [DEPTH_WORDS];

  logic [ADDR_WIDTH-1:0] w_offs;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_in_range, w_is_led, w_misal, w_err;
  size_e                 w_size;
  logic [31:0]           w_load_word, w_store_word;

  // Range test uses the unwrapped offset so addresses below BASE_ADDR never alias into RAM.
  always_comb begin
    w_offs     = r_addr - BASE_ADDR;
    w_idx      = w_offs[IDX_W+1:2];
    w_in_range = (r_addr >= BASE_ADDR) && ({1'b0, w_offs} < SPAN);
    w_is_led   = (r_addr == LED_ADDR);
    w_size     = decode_size(r_mask);
    w_misal    = ((w_size == SZ_HALF) && r_addr[0]) ||
                 ((w_size == SZ_WORD) && (r_addr[1:0] != 2'b00));
    w_err      = (w_size == SZ_NONE) || w_misal ||
                 (w_is_led ? (w_size != SZ_WORD) : !w_in_range);
  end

  data_mem_param_lane_fmt u_lane_fmt (
    .i_word       (r_word_buf),
    .i_wdata      (r_wdata),
    .i_offset     (r_addr[1:0]),
    .i_sign_mask  (r_mask),
    .o_load_word  (w_load_word),
    .o_store_word (w_store_word)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (io_bus.memread || io_bus.memwrite) w_next = ST_FETCH;
      ST_FETCH: w_next = r_is_load ? ST_LOAD : ST_STORE;
      ST_LOAD,
      ST_STORE: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_wdata     <= 32'h0;
      r_mask      <= 4'h0;
      r_is_load   <= 1'b0;
      r_word_buf  <= 32'h0;
      r_read_data <= 32'h0;
      r_led       <= 32'h0;
      r_stall     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_addr    <= io_bus.addr;
          r_wdata   <= io_bus.write_data;
          r_mask    <= io_bus.sign_mask;
          r_is_load <= io_bus.memread;
          if (io_bus.memread || io_bus.memwrite) r_stall <= 1'b1;
        end
        ST_FETCH: r_word_buf <= r_mem[w_idx];
        ST_LOAD: begin
          r_read_data <= w_err ? 32'h0 : (w_is_led ? r_led : w_load_word);
          r_stall     <= 1'b0;
          r_err       <= w_err;
        end
        ST_STORE: begin
          if (!w_err && w_is_led) r_led <= r_wdata;
          r_stall <= 1'b0;
          r_err   <= w_err;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && (r_state == ST_STORE) && !w_err && !w_is_led)
      r_mem[w_idx] <= w_store_word;
  end

  assign io_bus.read_data  = r_read_data;
  assign io_bus.clk_stall  = r_stall;
  assign io_bus.access_err = r_err;
  assign o_led             = r_led[LED_WIDTH-1:0];

endmodule

// File: tb/tb_data_mem_param.sv
// tb/tb_data_mem_param.sv - scoreboard bench for data_mem_param
// Expected load data / error flags are queued when a request is issued and compared when clk_stall falls.
module tb_data_mem_param;

  localparam int ADDR_WIDTH = 14;
  localparam int DEPTH      = 512;

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
    logic        chk_rd;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] led;
  int         total = 0;
  int         bad = 0;
  exp_t       q_exp[$];
  string      q_tag[$];

  data_mem_param_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

  data_mem_param #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (14'h1000),
    .LED_ADDR    (14'h2000),
    .LED_WIDTH   (8)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus),
    .o_led  (led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic op(input string tag, input logic rd, input logic wr, input logic [13:0] a,
                    input logic [31:0] d, input logic [3:0] m, input logic [31:0] exp_rd,
                    input logic exp_err);
    exp_t e;
    int   n;
    bus.addr       = a;
    bus.write_data = d;
    bus.sign_mask  = m;
    bus.memread    = rd;
    bus.memwrite   = wr;
    q_exp.push_back('{rd: exp_rd, err: exp_err, chk_rd: rd});
    q_tag.push_back(tag);
    @(posedge clk); #1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (!bus.clk_stall) break;
      n++;
      @(posedge clk); #1;
    end
    chk({tag, "_stall_cycles"}, n, 2);
    if (q_exp.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = q_exp.pop_front();
      tag = q_tag.pop_front();
      if (e.chk_rd) chk({tag, "_rdata"}, bus.read_data, e.rd);
      chk({tag, "_err"}, bus.access_err, e.err);
    end
    bus.memread  = 1'b0;
    bus.memwrite = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_err_pulse_end"}, bus.access_err, 0);
    chk({tag, "_stall_idle"}, bus.clk_stall, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] w, x;
    logic [13:0] a;
    logic [7:0]  b;
    logic [1:0]  lane;
    bus.addr = '0; bus.write_data = '0; bus.sign_mask = '0;
    bus.memread = 1'b0; bus.memwrite = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", bus.clk_stall, 0);
    chk("rst_rdata", bus.read_data, 0);
    chk("rst_err", bus.access_err, 0);
    chk("rst_led", led, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    op("sw_word", 0, 1, 14'h1004, 32'hDEADBEEF, 4'b0100, 32'h0, 0);
    op("lw_word", 1, 0, 14'h1004, 32'h0, 4'b0100, 32'hDEADBEEF, 0);

    op("sw_ext", 0, 1, 14'h1008, 32'h80FF7F01, 4'b0100, 32'h0, 0);
    op("lb", 1, 0, 14'h100B, 32'h0, 4'b1001, 32'hFFFFFF80, 0);
    op("lbu", 1, 0, 14'h100B, 32'h0, 4'b0001, 32'h00000080, 0);
    op("lh", 1, 0, 14'h100A, 32'h0, 4'b1010, 32'hFFFF80FF, 0);
    op("lhu", 1, 0, 14'h1008, 32'h0, 4'b0010, 32'h00007F01, 0);
    op("lb_pos", 1, 0, 14'h1008, 32'h0, 4'b1001, 32'h00000001, 0);

    op("sw_merge", 0, 1, 14'h100C, 32'h11223344, 4'b0100, 32'h0, 0);
    op("sb_merge", 0, 1, 14'h100D, 32'h000000AA, 4'b0001, 32'h0, 0);
    op("lw_after_sb", 1, 0, 14'h100C, 32'h0, 4'b0100, 32'h1122AA44, 0);
    op("sh_merge", 0, 1, 14'h100E, 32'h0000BEEF, 4'b0010, 32'h0, 0);
    op("lw_merge", 1, 0, 14'h100C, 32'h0, 4'b0100, 32'hBEEFAA44, 0);

    op("lw_misal", 1, 0, 14'h1006, 32'h0, 4'b0100, 32'h0, 1);
    op("lh_misal", 1, 0, 14'h1005, 32'h0, 4'b1010, 32'h0, 1);
    op("sh_misal", 0, 1, 14'h100D, 32'h00001234, 4'b0010, 32'h0, 1);
    op("lw_misal_chk", 1, 0, 14'h100C, 32'h0, 4'b0100, 32'hBEEFAA44, 0);

    op("sw_word0", 0, 1, 14'h1000, 32'h0BADF00D, 4'b0100, 32'h0, 0);
    op("sw_last", 0, 1, 14'h17FC, 32'h5A5A5A5A, 4'b0100, 32'h0, 0);
    op("sw_below", 0, 1, 14'h0FFC, 32'hFFFFFFFF, 4'b0100, 32'h0, 1);
    op("sw_above", 0, 1, 14'h1800, 32'hFFFFFFFF, 4'b0100, 32'h0, 1);
    op("lw_above", 1, 0, 14'h1800, 32'h0, 4'b0100, 32'h0, 1);
    op("lw_word0", 1, 0, 14'h1000, 32'h0, 4'b0100, 32'h0BADF00D, 0);
    op("lw_last", 1, 0, 14'h17FC, 32'h0, 4'b0100, 32'h5A5A5A5A, 0);

    chk("led_pre", led, 8'h00);
    op("sw_led", 0, 1, 14'h2000, 32'h000000A5, 4'b0100, 32'h0, 0);
    chk("led_set", led, 8'hA5);
    op("lw_led", 1, 0, 14'h2000, 32'h0, 4'b0100, 32'h000000A5, 0);
    op("sb_led", 0, 1, 14'h2000, 32'h00000011, 4'b0001, 32'h0, 1);
    chk("led_kept", led, 8'hA5);
    op("lh_led", 1, 0, 14'h2000, 32'h0, 4'b0010, 32'h0, 1);

    op("rd_wr_both", 1, 1, 14'h1004, 32'h00000000, 4'b0100, 32'hDEADBEEF, 0);
    op("lw_after_both", 1, 0, 14'h1004, 32'h0, 4'b0100, 32'hDEADBEEF, 0);
    op("lw_nosize", 1, 0, 14'h1004, 32'h0, 4'b0000, 32'h0, 1);

    for (int i = 0; i < 6; i++) begin
      a    = 14'h1100 + 14'(4 * $urandom_range(0, 63));
      w    = $urandom;
      b    = 8'($urandom);
      lane = 2'($urandom_range(0, 3));
      x    = w;
      x[8*lane +: 8] = b;
      op($sformatf("rnd%0d_sw", i), 0, 1, a, w, 4'b0100, 32'h0, 0);
      op($sformatf("rnd%0d_sb", i), 0, 1, a + 14'(lane), {24'h0, b}, 4'b0001, 32'h0, 0);
      op($sformatf("rnd%0d_lw", i), 1, 0, a, 32'h0, 4'b0100, x, 0);
    end

    op("sw_pre_rst", 0, 1, 14'h1010, 32'h12345678, 4'b0100, 32'h0, 0);
    bus.addr = 14'h1010; bus.write_data = 32'hCAFEF00D; bus.sign_mask = 4'b0100;
    bus.memwrite = 1'b1;
    @(posedge clk); #1;
    chk("abort_in_fetch", bus.clk_stall, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.memwrite = 1'b0;
    chk("abort_stall", bus.clk_stall, 0);
    chk("abort_led", led, 8'h00);
    chk("abort_rdata", bus.read_data, 0);
    @(posedge clk); #1;
    chk("abort_stall_later", bus.clk_stall, 0);
    op("lw_after_abort", 1, 0, 14'h1010, 32'h0, 4'b0100, 32'h12345678, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
